// File: rtl/requant_pkg.sv
// rtl/requant_pkg.sv - shared types, constants and helpers for the requantiser
package requant_pkg;

    typedef enum logic [1:0] {
        WAIT_ARM  = 2'd0,
        WAIT_SYNC = 2'd1,
        RUNNING   = 2'd2
    } state_t;

    // Signed product width: input component times zero-extended gain
    function automatic int prod_w(input int in_w, input int gain_w);
        return in_w + gain_w + 1;
    endfunction

    // Symmetric saturation magnitude; the most negative code is never emitted
    function automatic int sat_max(input int out_w);
        return (1 << (out_w - 1)) - 1;
    endfunction

    // Half an output LSB, added before the shift for round-half-up
    function automatic int rnd_const(input int frac);
        return 1 << (frac - 1);
    endfunction

    function automatic int chan_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_IN_W      = 12;
    localparam int DEF_GAIN_W    = 8;
    localparam int DEF_GAIN_FRAC = 4;
    localparam int DEF_OUT_W     = 8;
    localparam int PROD_W        = prod_w(DEF_IN_W, DEF_GAIN_W);
    localparam int SAT_MAX       = sat_max(DEF_OUT_W);
    localparam int SAT_MIN       = -SAT_MAX;
    localparam int RND_CONST     = rnd_const(DEF_GAIN_FRAC);

endpackage

// File: rtl/requant_lane.sv
// rtl/requant_lane.sv - one component: multiply, round, shift, saturate
module requant_lane
    import requant_pkg::*;
#(
    parameter int IN_W      = 12,
    parameter int GAIN_W    = 8,
    parameter int GAIN_FRAC = 4,
    parameter int OUT_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  s,
    input  logic [GAIN_W-1:0]       gain,
    input  logic                    round_en,
    output logic signed [OUT_W-1:0] q,
    output logic                    clip
);

    localparam int PW = prod_w(IN_W, GAIN_W);
    localparam logic signed [PW-1:0] P_SAT_MAX = PW'(sat_max(OUT_W));
    localparam logic signed [PW-1:0] P_SAT_MIN = -P_SAT_MAX;
    localparam logic signed [PW-1:0] P_RND     = PW'(rnd_const(GAIN_FRAC));

    logic signed [PW-1:0] prod_d;
    logic signed [PW-1:0] prod_q;
    logic signed [PW-1:0] shifted;

    // S1: signed product with the rounding offset folded in when enabled
    always_comb begin
        prod_d = PW'(s) * $signed(PW'({1'b0, gain}));
        if (round_en) begin
            prod_d = prod_d + P_RND;
        end
    end

    // S1 product register
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
        end else begin
            prod_q <= prod_d;
        end
    end

    // S2 combinational half: drop fraction bits, clamp symmetrically
    always_comb begin
        shifted = prod_q >>> GAIN_FRAC;
        q       = shifted[OUT_W-1:0];
        clip    = 1'b0;
        if (shifted > P_SAT_MAX) begin
            q    = P_SAT_MAX[OUT_W-1:0];
            clip = 1'b1;
        end else if (shifted < P_SAT_MIN) begin
            q    = P_SAT_MIN[OUT_W-1:0];
            clip = 1'b1;
        end
    end

endmodule

// File: rtl/requant_pipe.sv
// rtl/requant_pipe.sv - arm/sync sequencer and 3-stage complex requantiser
module requant_pipe
    import requant_pkg::*;
#(
    parameter  int IN_W      = 12,
    parameter  int GAIN_W    = 8,
    parameter  int GAIN_FRAC = 4,
    parameter  int OUT_W     = 8,
    parameter  int N_CHAN    = 2048,
    localparam int CHAN_W    = chan_w(N_CHAN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 arm,
    input  logic                 sync_in,
    input  logic [2*IN_W-1:0]    requant_in,
    input  logic                 round_en,
    output logic [CHAN_W-1:0]    addr,
    input  logic [GAIN_W-1:0]    gain,
    output logic [2*OUT_W-1:0]   requant_out,
    output logic                 valid_out,
    output logic                 sync_out,
    output logic                 overflow,
    output logic [15:0]          ovf_count
);

    state_t state_q, state_d;
    logic [CHAN_W-1:0] chan_q, chan_d;
    logic pend_q, pend_d;
    logic accept, sync_start;

    logic s0_valid_q, s0_valid_d, s0_first_q, s0_first_d;
    logic signed [IN_W-1:0] s0_re_q, s0_re_d, s0_im_q, s0_im_d;
    logic s1_valid_q, s1_valid_d, s1_first_q, s1_first_d;

    logic [2*OUT_W-1:0] data_q, data_d;
    logic valid_q, valid_d, sync_q, sync_d, ovf_q, ovf_d;
    logic [15:0] cnt_q, cnt_d;

    logic signed [OUT_W-1:0] q_re, q_im;
    logic clip_re, clip_im;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_ARM;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: sync only matters in WAIT_SYNC, where it beats arm
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_ARM:  if (arm) state_d = WAIT_SYNC;
            WAIT_SYNC: if (sync_in && ce) state_d = RUNNING;
            RUNNING:   if (arm) state_d = WAIT_SYNC;
            default:   state_d = WAIT_ARM;
        endcase
    end

    // FSM outputs: sample acceptance, sync capture and gain RAM address
    always_comb begin
        accept     = ce && (state_q == RUNNING);
        sync_start = (state_q == WAIT_SYNC) && sync_in && ce;
        addr       = (state_q == RUNNING) ? chan_q : '0;
    end

    // Channel counter and pending-sync flag
    always_comb begin
        chan_d = chan_q;
        pend_d = pend_q;
        if (sync_start) begin
            chan_d = '0;
            pend_d = 1'b1;
        end else if ((state_q == RUNNING) && arm) begin
            chan_d = '0;
            pend_d = 1'b0;
        end else if (accept) begin
            chan_d = chan_q + 1'b1;
            if (chan_q == '0) begin
                pend_d = 1'b0;
            end
        end
    end

    // Valid/first tags ride alongside the data; the lanes hold the product
    always_comb begin
        s0_valid_d = accept;
        s0_first_d = accept && pend_q && (chan_q == '0);
        s0_re_d    = requant_in[2*IN_W-1:IN_W];
        s0_im_d    = requant_in[IN_W-1:0];
        s1_valid_d = s0_valid_q;
        s1_first_d = s0_first_q;
        valid_d    = s1_valid_q;
        sync_d     = s1_valid_q && s1_first_q;
        ovf_d      = s1_valid_q && (clip_re || clip_im);
        data_d     = s1_valid_q ? {q_re, q_im} : data_q;
        cnt_d      = cnt_q;
        if (arm) begin
            cnt_d = '0;
        end else if (ovf_d && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // All sequential state; reset drops every in-flight valid at once
    always_ff @(posedge clk) begin
        if (rst) begin
            chan_q     <= '0;
            pend_q     <= 1'b0;
            s0_valid_q <= 1'b0;
            s0_first_q <= 1'b0;
            s0_re_q    <= '0;
            s0_im_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            sync_q     <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            chan_q     <= chan_d;
            pend_q     <= pend_d;
            s0_valid_q <= s0_valid_d;
            s0_first_q <= s0_first_d;
            s0_re_q    <= s0_re_d;
            s0_im_q    <= s0_im_d;
            s1_valid_q <= s1_valid_d;
            s1_first_q <= s1_first_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            sync_q     <= sync_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
        end
    end

    requant_lane #(
        .IN_W(IN_W), .GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC), .OUT_W(OUT_W)
    ) u_lane_re (
        .clk(clk), .rst(rst), .s(s0_re_q), .gain(gain),
        .round_en(round_en), .q(q_re), .clip(clip_re)
    );

    requant_lane #(
        .IN_W(IN_W), .GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC), .OUT_W(OUT_W)
    ) u_lane_im (
        .clk(clk), .rst(rst), .s(s0_im_q), .gain(gain),
        .round_en(round_en), .q(q_im), .clip(clip_im)
    );

    assign requant_out = data_q;
    assign valid_out   = valid_q;
    assign sync_out    = sync_q;
    assign overflow    = ovf_q;
    assign ovf_count   = cnt_q;

endmodule

// File: tb/tb_requant_pipe.sv
// tb/tb_requant_pipe.sv - directed self-checking bench for requant_pipe
module tb_requant_pipe;

    logic        clk = 1'b0;
    logic        rst, ce, arm, sync_in, round_en;
    logic [23:0] requant_in;
    logic [7:0]  gain;
    logic [2:0]  addr;
    logic [15:0] requant_out;
    logic        valid_out, sync_out, overflow;
    logic [15:0] ovf_count;

    int tests = 0;
    int fails = 0;

    logic [7:0] gain_mem [8];
    bit pv [3];
    bit ps [3];
    bit po [3];
    int pre [3];
    int pim [3];

    logic signed [7:0] re_o, im_o;
    assign re_o = requant_out[15:8];
    assign im_o = requant_out[7:0];

    requant_pipe #(
        .IN_W(12), .GAIN_W(8), .GAIN_FRAC(4), .OUT_W(8), .N_CHAN(8)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .arm(arm), .sync_in(sync_in),
        .requant_in(requant_in), .round_en(round_en), .addr(addr),
        .gain(gain), .requant_out(requant_out), .valid_out(valid_out),
        .sync_out(sync_out), .overflow(overflow), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    // Gain RAM: one clock read latency
    always @(posedge clk) gain <= gain_mem[addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit c, input bit a, input bit s, input int re, input int im);
        ce         = c;
        arm        = a;
        sync_in    = s;
        requant_in = {re[11:0], im[11:0]};
    endtask

    task automatic set_gain(input int g);
        for (int i = 0; i < 8; i++) gain_mem[i] = g[7:0];
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            pv[i] = 0; ps[i] = 0; po[i] = 0; pre[i] = 0; pim[i] = 0;
        end
    endtask

    // One clock; a sample accepted at this edge is due two edges later
    task automatic step(input bit acc, input int ere, input int eim, input bit es, input bit eo);
        @(posedge clk);
        #1;
        for (int i = 2; i > 0; i--) begin
            pv[i] = pv[i-1]; ps[i] = ps[i-1]; po[i] = po[i-1];
            pre[i] = pre[i-1]; pim[i] = pim[i-1];
        end
        pv[0] = acc; pre[0] = ere; pim[0] = eim; ps[0] = es; po[0] = eo;
        check("valid_out", valid_out, pv[2]);
        if (pv[2]) begin
            check("re", int'(re_o), pre[2]);
            check("im", int'(im_o), pim[2]);
            check("sync_out", sync_out, ps[2]);
            check("overflow", overflow, po[2]);
        end else begin
            check("sync_idle", sync_out, 0);
            check("ovf_idle", overflow, 0);
        end
    endtask

    task automatic step0();
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        round_en = 1'b0;
        set_in(0, 0, 0, 0, 0);
        set_gain(16);
        clear_model();
        step0();
        step0();
        rst = 1'b0;
        check("rst_data", requant_out, 0);
        check("rst_sync", sync_out, 0);
        check("rst_ovf", overflow, 0);
        check("rst_cnt", ovf_count, 0);
        check("rst_addr", addr, 0);

        // Sync before arm is ignored
        set_in(1, 0, 1, 0, 0); step0();
        set_in(1, 0, 0, 7, 7); step0(); step0(); step0();
        check("noarm_addr", addr, 0);

        // Arm, then arm+sync together in WAIT_SYNC starts running
        set_in(0, 1, 0, 0, 0); step0();
        set_in(1, 1, 1, 0, 0); step0();
        check("run_addr0", addr, 0);

        // Unity gain, first sample carries sync_out
        set_in(1, 0, 0, 100, -5); step(1, 100, -5, 1, 0);
        set_in(0, 0, 0, 0, 0); step0(); step0(); step0();

        // Truncate vs round, round_en switched between the two S1 entries
        set_gain(8);
        set_in(1, 0, 0, -3, 3); step(1, -2, 1, 0, 0);
        set_in(1, 0, 0, -3, 3); step(1, -1, 2, 0, 0);
        round_en = 1'b1;
        set_in(0, 0, 0, 0, 0); step0(); step0();
        round_en = 1'b0;

        // Single saturating sample
        set_gain(255);
        set_in(1, 0, 0, 2047, -2048); step(1, 127, -127, 0, 1);
        set_in(0, 0, 0, 0, 0); step0(); step0();
        check("ovf_cnt_1", ovf_count, 1);

        // Re-arm while channel 5 is in S0: in-flight samples still emerge
        set_gain(16);
        set_in(1, 0, 0, 10, -10); step(1, 10, -10, 0, 0);
        set_in(1, 0, 0, 20, -20); step(1, 20, -20, 0, 0);
        set_in(0, 1, 0, 0, 0); step0();
        check("rearm_cnt", ovf_count, 0);
        check("rearm_addr", addr, 0);
        set_in(1, 0, 0, 77, 77); step0(); step0(); step0(); step0();
        check("rearm_cnt2", ovf_count, 0);

        // New sync: addr restarts, wraps, and a ce gap keeps order
        set_in(1, 0, 1, 0, 0); step0();
        for (int i = 0; i < 10; i++) begin
            check("seq_addr", addr, i % 8);
            set_in(1, 0, 0, i + 1, -(i + 1));
            step(1, i + 1, -(i + 1), i == 0, 0);
            if (i == 4) begin
                set_in(0, 0, 0, 0, 0); step0();
                check("gap_addr", addr, 5);
            end
        end
        set_in(0, 0, 0, 0, 0); step0(); step0(); step0();

        // Long saturation run pins the counter
        set_gain(255);
        round_en = 1'b1;
        set_in(1, 0, 0, 2047, -2048);
        for (int i = 0; i < 70000; i++) step(1, 127, -127, 0, 1);
        set_in(0, 0, 0, 0, 0); step0(); step0(); step0();
        check("ovf_cnt_sat", ovf_count, 16'hFFFF);
        round_en = 1'b0;

        // Reset with samples in flight
        set_gain(16);
        set_in(1, 0, 0, 5, 5);
        step(1, 5, 5, 0, 0); step(1, 5, 5, 0, 0); step(1, 5, 5, 0, 0);
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0);
        clear_model();
        step0();
        rst = 1'b0;
        check("mrst_data", requant_out, 0);
        check("mrst_cnt", ovf_count, 0);
        check("mrst_addr", addr, 0);
        step0(); step0();

        // Back in WAIT_ARM: sync ignored, arm+sync only reaches WAIT_SYNC
        set_in(1, 0, 1, 9, 9); step0();
        set_in(1, 0, 0, 9, 9); step0(); step0();
        set_in(1, 1, 1, 9, 9); step0();
        set_in(1, 0, 0, 9, 9); step0(); step0(); step0();
        check("warm_addr", addr, 0);
        set_in(1, 0, 1, 0, 0); step0();
        set_in(1, 0, 0, 33, -33); step(1, 33, -33, 1, 0);
        set_in(0, 0, 0, 0, 0); step0(); step0(); step0();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
